// File: rtl/wb_commit_tracer_if.sv
// Trace output stream of the writeback commit tracer: FWFT head entry plus valid/ready.
// master = tracer side, slave = consumer side.
interface wb_commit_tracer_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [31:0] out_cycle;

  modport master (
    output out_valid, out_reg, out_data, out_cycle,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_reg, out_data, out_cycle,
    output out_ready
  );
endinterface

// File: rtl/wb_commit_tracer.sv
// Writeback commit tracer: timestamps qualifying register-file writes into an FWFT FIFO
// and keeps commit/overflow statistics so dropped entries can be detected.
module wb_commit_tracer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  WB_RegWrite,
  input  logic [4:0]            WB_WriteReg,
  input  logic [31:0]           WB_WriteData,
  input  logic                  Enable,
  input  logic                  Clear,
  wb_commit_tracer_if.master    trc,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic [31:0]           commit_cnt,
  output logic [15:0]           overflow_cnt
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [31:0]   cyc;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  logic [4:0]    memReg   [0:DEPTH-1];
  logic [31:0]   memData  [0:DEPTH-1];
  logic [31:0]   memCycle [0:DEPTH-1];

  logic commitQ;
  logic popQ;
  logic pushQ;
  logic dropQ;

  assign full    = (count == FullCnt);
  assign empty   = (count == '0);
  assign commitQ = Enable & WB_RegWrite & (WB_WriteReg != 5'd0);
  assign popQ    = trc.out_valid & trc.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pushQ   = commitQ & (~full | popQ);
  assign dropQ   = commitQ & full & ~popQ;

  assign trc.out_valid = ~empty;
  assign trc.out_reg   = empty ? 5'd0  : memReg[rdPtr];
  assign trc.out_data  = empty ? 32'd0 : memData[rdPtr];
  assign trc.out_cycle = empty ? 32'd0 : memCycle[rdPtr];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc          <= '0;
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      commit_cnt   <= '0;
      overflow_cnt <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (Clear) begin
        wrPtr        <= '0;
        rdPtr        <= '0;
        count        <= '0;
        commit_cnt   <= '0;
        overflow_cnt <= '0;
      end else begin
        if (pushQ) wrPtr <= wrPtr + 1'b1;
        if (popQ)  rdPtr <= rdPtr + 1'b1;
        case ({pushQ, popQ})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (commitQ) commit_cnt <= commit_cnt + 32'd1;
        if (dropQ && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  // Storage is not reset; reads are masked while empty.
  always_ff @(posedge Clk) begin
    if (Reset && !Clear && pushQ) begin
      memReg[wrPtr]   <= WB_WriteReg;
      memData[wrPtr]  <= WB_WriteData;
      memCycle[wrPtr] <= cyc;
    end
  end

endmodule

// File: tb/tb_wb_commit_tracer.sv
// Directed bench for wb_commit_tracer: filtering, capture, overflow, full push/pop,
// streaming wrap-around, Clear and mid-stream Reset.
module tb_wb_commit_tracer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        Enable;
  logic        Clear;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [31:0] commit_cnt;
  logic [15:0] overflow_cnt;

  wb_commit_tracer_if trc();

  wb_commit_tracer #(.DEPTH(16), .AW(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .WB_RegWrite  (WB_RegWrite),
    .WB_WriteReg  (WB_WriteReg),
    .WB_WriteData (WB_WriteData),
    .Enable       (Enable),
    .Clear        (Clear),
    .trc          (trc),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .commit_cnt   (commit_cnt),
    .overflow_cnt (overflow_cnt)
  );

  always #5 Clk = ~Clk;

  int vecCnt = 0;
  int missCnt = 0;
  int nowCyc = 0;
  int fillBase;
  int lastStamp;

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", tag, obs, exp, nowCyc);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
    nowCyc++;
  endtask

  task automatic setWb(input logic en, input logic rw, input logic [4:0] r, input logic [31:0] d);
    Enable = en;
    WB_RegWrite = rw;
    WB_WriteReg = r;
    WB_WriteData = d;
  endtask

  task automatic chkReset(input string tag);
    chkVal({tag, "_valid"},    32'(trc.out_valid), 32'd0);
    chkVal({tag, "_count"},    32'(count), 32'd0);
    chkVal({tag, "_empty"},    32'(empty), 32'd1);
    chkVal({tag, "_full"},     32'(full), 32'd0);
    chkVal({tag, "_reg"},      32'(trc.out_reg), 32'd0);
    chkVal({tag, "_data"},     trc.out_data, 32'd0);
    chkVal({tag, "_cycle"},    trc.out_cycle, 32'd0);
    chkVal({tag, "_commit"},   commit_cnt, 32'd0);
    chkVal({tag, "_overflow"}, 32'(overflow_cnt), 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    Clear = 1'b0;
    trc.out_ready = 1'b0;
    setWb(1'b0, 1'b0, 5'd0, 32'd0);
    repeat (3) tick;
    Reset = 1'b1;
    nowCyc = 0;
    chkReset("rst");

    // Filtering in cycles 0..2
    setWb(1'b1, 1'b1, 5'd0, 32'h1111);  tick;
    setWb(1'b0, 1'b1, 5'd7, 32'h2222);  tick;
    setWb(1'b1, 1'b0, 5'd12, 32'h3333); tick;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("filt_count",  32'(count), 32'd0);
    chkVal("filt_commit", commit_cnt, 32'd0);
    tick;

    // Basic capture at cyc 4
    chkVal("cap_cyc_is4", 32'(nowCyc), 32'd4);
    setWb(1'b1, 1'b1, 5'd9, 32'h5);
    tick;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("cap_valid",  32'(trc.out_valid), 32'd1);
    chkVal("cap_reg",    32'(trc.out_reg), 32'd9);
    chkVal("cap_data",   trc.out_data, 32'd5);
    chkVal("cap_cycle",  trc.out_cycle, 32'd4);
    chkVal("cap_count",  32'(count), 32'd1);
    chkVal("cap_commit", commit_cnt, 32'd1);
    trc.out_ready = 1'b1;
    tick;
    trc.out_ready = 1'b0;
    chkVal("pop_empty", 32'(empty), 32'd1);
    chkVal("pop_mask",  trc.out_data, 32'd0);

    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    chkVal("clr0_commit", commit_cnt, 32'd0);

    // Fill and overflow: 18 commits, regs 1..18
    fillBase = nowCyc;
    for (int k = 1; k <= 18; k++) begin
      setWb(1'b1, 1'b1, 5'(k), 32'(k * 16));
      tick;
    end
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("fill_full",     32'(full), 32'd1);
    chkVal("fill_count",    32'(count), 32'd16);
    chkVal("fill_overflow", 32'(overflow_cnt), 32'd2);
    chkVal("fill_commit",   commit_cnt, 32'd18);

    // Push and pop while full
    chkVal("pp_head_reg",   32'(trc.out_reg), 32'd1);
    chkVal("pp_head_cycle", trc.out_cycle, 32'(fillBase));
    setWb(1'b1, 1'b1, 5'd20, 32'hABCD);
    lastStamp = nowCyc;
    trc.out_ready = 1'b1;
    tick;
    trc.out_ready = 1'b0;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("pp_count",    32'(count), 32'd16);
    chkVal("pp_overflow", 32'(overflow_cnt), 32'd2);
    chkVal("pp_commit",   commit_cnt, 32'd19);

    trc.out_ready = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      chkVal("drain_reg",   32'(trc.out_reg), 32'(k));
      chkVal("drain_data",  trc.out_data, 32'(k * 16));
      chkVal("drain_cycle", trc.out_cycle, 32'(fillBase + k - 1));
      tick;
    end
    chkVal("drain_last_reg",   32'(trc.out_reg), 32'd20);
    chkVal("drain_last_data",  trc.out_data, 32'hABCD);
    chkVal("drain_last_cycle", trc.out_cycle, 32'(lastStamp));
    tick;
    chkVal("drain_empty", 32'(empty), 32'd1);

    // Streaming with out_ready held: pointers wrap, never more than one entry
    for (int i = 0; i < 40; i++) begin
      setWb(1'b1, 1'b1, 5'((i % 31) + 1), 32'(i * 3 + 7));
      lastStamp = nowCyc;
      tick;
      chkVal("strm_count", 32'(count), 32'd1);
      chkVal("strm_reg",   32'(trc.out_reg), 32'((i % 31) + 1));
      chkVal("strm_data",  trc.out_data, 32'(i * 3 + 7));
      chkVal("strm_cycle", trc.out_cycle, 32'(lastStamp));
    end
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    tick;
    chkVal("strm_empty",    32'(empty), 32'd1);
    chkVal("strm_overflow", 32'(overflow_cnt), 32'd2);
    chkVal("strm_commit",   commit_cnt, 32'd59);
    trc.out_ready = 1'b0;

    // Clear mid-stream with a commit in the same cycle
    for (int i = 0; i < 5; i++) begin
      setWb(1'b1, 1'b1, 5'(i + 3), 32'(i));
      tick;
    end
    chkVal("pre_clr_count", 32'(count), 32'd5);
    setWb(1'b1, 1'b1, 5'd30, 32'hDEAD);
    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("clr_count",  32'(count), 32'd0);
    chkVal("clr_commit", commit_cnt, 32'd0);
    chkVal("clr_empty",  32'(empty), 32'd1);
    setWb(1'b1, 1'b1, 5'd4, 32'h44);
    lastStamp = nowCyc;
    tick;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("clr_cyc_runs", trc.out_cycle, 32'(lastStamp));
    chkVal("clr_commit1",  commit_cnt, 32'd1);

    // Reset with entries queued
    for (int i = 0; i < 3; i++) begin
      setWb(1'b1, 1'b1, 5'(i + 1), 32'(i));
      tick;
    end
    chkVal("pre_rst_count", 32'(count), 32'd4);
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
    nowCyc = 0;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkReset("rst2");
    setWb(1'b1, 1'b1, 5'd17, 32'h77);
    tick;
    setWb(1'b1, 1'b0, 5'd0, 32'd0);
    chkVal("rst2_stamp0", trc.out_cycle, 32'd0);
    chkVal("rst2_reg",    32'(trc.out_reg), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/wb_commit_tracer.md
# wb_commit_tracer

Writeback commit tracer that sits directly downstream of the 5-stage pipeline's WB stage. It samples every register-file write the core commits (`WB_RegWrite`, `WB_WriteReg`, `WB_WriteData`) and timestamps it with a free-running cycle counter. Entries go into a first-word-fall-through FIFO that a testbench or debug port drains through a valid/ready handshake. It also keeps commit and overflow statistics, so dropped entries can be detected.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `AW`, 4: log2(`DEPTH`).
- `Clk` in 1: single clock; all state updates on posedge.
- `Reset` in 1: synchronous, active-low reset. Sampled on posedge `Clk`; no asynchronous path.
- `WB_RegWrite` in 1: WB-stage write enable from the core.
- `WB_WriteReg` in 5: WB-stage destination register index.
- `WB_WriteData` in 32: WB-stage write data.
- `Enable` in 1: capture enable. While 0, no captures and no commit counting.
- `Clear` in 1: synchronous flush of FIFO and statistics.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_reg` out 5: head entry register index.
- `out_data` out 32: head entry data.
- `out_cycle` out 32: head entry cycle stamp.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `commit_cnt` out 32: qualifying commits seen, including dropped ones. Wraps modulo 2^32.
- `overflow_cnt` out 16: commits dropped because the FIFO was full. Saturates at 16'hFFFF.

## Operation
- Qualifying commit (`q`) = `Enable & WB_RegWrite & (WB_WriteReg != 0)`. Writes to $0 are never traced or counted.
- Cycle counter `cyc`:
  - 0 in the first cycle after `Reset` deasserts; increments by 1 every cycle; wraps at 2^32.
  - `Clear` does not affect it.
- Stamp = value of `cyc` during the cycle the commit is presented on the WB ports.
- Pop `p` = `out_valid & out_ready`.
- Push: when `q` and (`!full` or `p`), write {reg, data, stamp} at the tail and advance the tail pointer.
  - Push while full is allowed only when a pop happens in the same cycle; `count` stays `DEPTH`.
- Drop: when `q & full & !p`. The entry is discarded and `overflow_cnt` increments, saturating.
- `commit_cnt` increments on every `q`, whether pushed or dropped.
- Occupancy update:
  - push and pop together: `count` unchanged.
  - push only: +1.
  - pop only: −1.
- Pointers are AW bits and wrap from DEPTH−1 to 0. `full`/`empty` are derived from `count`, not from pointer equality alone.
- Output is FWFT: `out_valid = !empty`, and `out_*` show the head entry.
  - When empty, `out_reg`/`out_data`/`out_cycle` are driven to 0.
  - A pop with `out_valid = 0` is ignored.
- `Clear` (when `Reset` = 1):
  - Sets pointers, `count`, `commit_cnt` and `overflow_cnt` to 0.
  - Has priority over any push, pop or count that cycle; a commit in that cycle is neither stored nor counted.
- `Reset` = 0 overrides everything, `Clear` included.

## Timing
- Reset values (cycle after posedge with `Reset` = 0):
  - `out_valid` = 0, `count` = 0, `empty` = 1, `full` = 0.
  - `out_reg`/`out_data`/`out_cycle` = 0.
  - `commit_cnt` = 0, `overflow_cnt` = 0, `cyc` = 0.
- Reset mid-operation discards all entries; there is no drain.
- Push-to-visible latency: an entry captured at posedge N appears on `out_*` with `out_valid` = 1 in cycle N+1 when the FIFO was empty.
- Pop: on the posedge where `p` = 1, the head advances; the next entry (or empty/zero outputs) is visible in the following cycle.
- `count`, `full`, `empty`, `commit_cnt` and `overflow_cnt` are registered and reflect the posedge just taken.
- Sustained throughput: one push and one pop per cycle. The FIFO never drops while `out_ready` is held at 1.
- Storage array does not need to be reset; `out_*` are masked to 0 while empty.

## Test plan
- **Reset and basic capture.**
  - Stimulus: hold `Reset` = 0 for 3 cycles, release. Commit reg 9 = 32'h0000_0005 at `cyc` = 4, with `out_ready` = 0.
  - Response: at `cyc` 5, `out_valid` = 1, `out_reg` = 9, `out_data` = 5, `out_cycle` = 4, `count` = 1, `commit_cnt` = 1.
- **Filtering.**
  - Stimulus: write to $0, write with `Enable` = 0, and `WB_RegWrite` = 0 with reg 12.
  - Response: `count` stays 0 and `commit_cnt` stays 0.
- **Fill and overflow.**
  - Stimulus: `out_ready` = 0, 18 consecutive commits to regs 1..18 with data = reg×16.
  - Response: `full` = 1, `count` = 16, `overflow_cnt` = 2, `commit_cnt` = 18. Draining yields regs 1..16 in order, with stamps incrementing by 1.
- **Push and pop while full.**
  - Stimulus: FIFO full, then one cycle with commit reg 20 and `out_ready` = 1.
  - Response: `count` stays 16, `overflow_cnt` unchanged; reg 20 is the last entry drained.
- **Wrap-around streaming.**
  - Stimulus: `out_ready` = 1, 40 back-to-back commits.
  - Response: no drops; the output sequence matches the input in order; `count` never exceeds 1.
- **Clear and reset mid-stream.**
  - Stimulus: with 5 entries queued, pulse `Clear` alongside a commit; later assert `Reset` with entries queued.
  - Response: after `Clear`, `count` = 0, `commit_cnt` = 0, `cyc` keeps running. After `Reset`, all outputs are at their reset values.
